// File: rtl/fws_pkg.sv
// Shared constants, state encoding and rectangle descriptor for frame_write_scheduler.
package fws_pkg;

    localparam int unsigned H_RES    = 640;
    localparam int unsigned V_RES    = 480;
    localparam int unsigned FB_DEPTH = 307200;
    localparam int unsigned FB_AW    = 19;
    localparam int unsigned CW       = 11;   // coordinate width; x+w and y+h never wrap
    localparam int unsigned DW       = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ARB   = 3'd2,
        ST_FILL  = 3'd3,
        ST_DONE  = 3'd4
    } fws_state_t;

    typedef struct packed {
        logic [9:0]    x;
        logic [9:0]    y;
        logic [9:0]    w;
        logic [9:0]    h;
        logic [DW-1:0] color;
    } rect_t;

    // y*640 + x as (y<<9)+(y<<7)+x, truncated to the buffer address width
    function automatic logic [FB_AW-1:0] pix_addr(input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [FB_AW-1:0] yy;
        yy = FB_AW'(y);
        return (yy << 9) + (yy << 7) + FB_AW'(x);
    endfunction

endpackage

// File: rtl/frame_write_scheduler_if.sv
// Requester, control and frame-buffer write signals of frame_write_scheduler.
interface frame_write_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    import fws_pkg::*;

    logic                          start;
    logic                          finish;
    logic [DW-1:0]                 bg_color;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][9:0]       req_x;
    logic [NUM_REQ-1:0][9:0]       req_y;
    logic [NUM_REQ-1:0][9:0]       req_w;
    logic [NUM_REQ-1:0][9:0]       req_h;
    logic [NUM_REQ-1:0][DW-1:0]    req_color;
    logic [NUM_REQ-1:0]            req_ready;
    logic [FB_AW-1:0]              fb_wraddress;
    logic [DW-1:0]                 fb_data;
    logic                          fb_wren;
    logic                          busy;
    logic                          done;

    modport master (
        output start, finish, bg_color, req_valid, req_x, req_y, req_w, req_h, req_color,
        input  req_ready, fb_wraddress, fb_data, fb_wren, busy, done
    );

    modport slave (
        input  start, finish, bg_color, req_valid, req_x, req_y, req_w, req_h, req_color,
        output req_ready, fb_wraddress, fb_data, fb_wren, busy, done
    );

endinterface

// File: rtl/fws_rr_arbiter.sv
// Round-robin pick: first set req_valid bit at or after rr_ptr (combinational outputs).
module fws_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IW-1:0]      rr_ptr_i,
    output logic [IW-1:0]      grant_idx_o,
    output logic               found_o
);

    // Scan NUM_REQ slots from the pointer, wrapping, keep the first hit
    always_comb begin
        int unsigned idx;
        logic [IW-1:0] idx_w;
        grant_idx_o = '0;
        found_o     = 1'b0;
        idx         = 0;
        idx_w       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = IW'(idx);
            if (!found_o && req_valid_i[idx_w]) begin
                found_o     = 1'b1;
                grant_idx_o = idx_w;
            end
        end
    end

endmodule

// File: rtl/frame_write_scheduler.sv
// frame_write_scheduler: optional background clear, then round-robin rectangle fills
// into the 640x480x8 frame buffer write port. Build option: FWS_CLEAR_EN enables CLEAR.
module frame_write_scheduler
    import fws_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    frame_write_scheduler_if.slave  bus
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    fws_state_t         state_q;
    logic [IW-1:0]      rr_ptr_q;
    rect_t              rect_q;
    logic [CW-1:0]      cx_q;
    logic [CW-1:0]      cy_q;
    logic [NUM_REQ-1:0] req_ready_q;
    logic [FB_AW-1:0]   fb_addr_q;
    logic [DW-1:0]      fb_data_q;
    logic               fb_wren_q;
    logic               busy_q;
    logic               done_q;

    logic [IW-1:0]      grant_idx_c;
    logic               found_c;
    rect_t              sel_c;
    logic [CW-1:0]      x_last_c;
    logic [CW-1:0]      y_last_c;
    logic               rect_empty_c;
    logic               on_screen_c;

`ifdef FWS_CLEAR_EN
    logic [FB_AW-1:0]   clr_cnt_q;
    logic [DW-1:0]      bg_q;
`else
    logic [DW-1:0]      unused_bg;
    assign unused_bg = bus.bg_color;
`endif

    fws_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req_valid_i (bus.req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_idx_o (grant_idx_c),
        .found_o     (found_c)
    );

    // Descriptor of the current arbitration winner
    always_comb begin
        sel_c.x     = bus.req_x[grant_idx_c];
        sel_c.y     = bus.req_y[grant_idx_c];
        sel_c.w     = bus.req_w[grant_idx_c];
        sel_c.h     = bus.req_h[grant_idx_c];
        sel_c.color = bus.req_color[grant_idx_c];
    end

    // Raster-scan bounds and visibility of the current fill pixel
    always_comb begin
        x_last_c     = CW'(rect_q.x) + CW'(rect_q.w) - CW'(1);
        y_last_c     = CW'(rect_q.y) + CW'(rect_q.h) - CW'(1);
        rect_empty_c = (rect_q.w == '0) || (rect_q.h == '0);
        on_screen_c  = (cx_q < CW'(H_RES)) && (cy_q < CW'(V_RES));
    end

    // Scheduler FSM with registered frame-buffer and handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            rect_q      <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            req_ready_q <= '0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            fb_wren_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef FWS_CLEAR_EN
            clr_cnt_q   <= '0;
            bg_q        <= '0;
`endif
        end else begin
            req_ready_q <= '0;
            fb_wren_q   <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_q    <= 1'b1;
`ifdef FWS_CLEAR_EN
                        bg_q      <= bus.bg_color;
                        clr_cnt_q <= '0;
                        state_q   <= ST_CLEAR;
`else
                        state_q   <= ST_ARB;
`endif
                    end
                end
                ST_CLEAR: begin
`ifdef FWS_CLEAR_EN
                    fb_wren_q <= 1'b1;
                    fb_addr_q <= clr_cnt_q;
                    fb_data_q <= bg_q;
                    if (clr_cnt_q == FB_AW'(FB_DEPTH - 1)) begin
                        state_q <= ST_ARB;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + FB_AW'(1);
                    end
`else
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
`endif
                end
                ST_ARB: begin
                    // a pending request wins over finish in the same cycle
                    if (found_c) begin
                        req_ready_q[grant_idx_c] <= 1'b1;
                        rect_q   <= sel_c;
                        cx_q     <= CW'(sel_c.x);
                        cy_q     <= CW'(sel_c.y);
                        rr_ptr_q <= (grant_idx_c == IW'(NUM_REQ - 1)) ? '0 : grant_idx_c + IW'(1);
                        state_q  <= ST_FILL;
                    end else if (bus.finish) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_FILL: begin
                    if (rect_empty_c) begin
                        state_q <= ST_ARB;
                    end else begin
                        fb_wren_q <= on_screen_c;
                        fb_addr_q <= pix_addr(cx_q, cy_q);
                        fb_data_q <= rect_q.color;
                        if (cx_q == x_last_c) begin
                            cx_q <= CW'(rect_q.x);
                            if (cy_q == y_last_c) begin
                                state_q <= ST_ARB;
                            end else begin
                                cy_q <= cy_q + CW'(1);
                            end
                        end else begin
                            cx_q <= cx_q + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.fb_wraddress = fb_addr_q;
    assign bus.fb_data      = fb_data_q;
    assign bus.fb_wren      = fb_wren_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule
